eth_tx_arbiter: RTL

//  Shares the single Ethernet MAC TX frame engine between the ARP responder and NUM_REQ

---
 rtl/eth_tx_arbiter_pkg.sv | 15 +
 rtl/eth_tx_arbiter_if.sv | 29 ++
 rtl/eth_tx_arbiter_rr_arbiter.sv | 33 +++
 rtl/eth_tx_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/eth_tx_arbiter_pkg.sv
// Shared types for the Ethernet TX arbiter: FSM states, source ids, width helper.
package eth_tx_arbiter_pkg;

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} tx_arb_state_t;

   typedef logic [2:0] tx_src_t;

   localparam tx_src_t SRC_ARP = 3'd0;

   // Index width that stays legal (>= 1 bit) for single-entry ranges.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Frame-source / MAC TX handshake bundle; master = arbiter, slave = sources and MAC.
interface eth_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 2
) ();
   import eth_tx_arbiter_pkg::*;

   logic               arp_resp_req;
   logic               arp_gnt;
   logic               arp_done;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] done;
   logic               tx_start;
   tx_src_t            tx_sel;
   logic               tx_done;
   logic               tx_abort;
   logic [7:0]         arp_drop_cnt;

   modport master (
      input  arp_resp_req, req, tx_done,
      output arp_gnt, arp_done, gnt, done, tx_start, tx_sel, tx_abort, arp_drop_cnt
   );

   modport slave (
      output arp_resp_req, req, tx_done,
      input  arp_gnt, arp_done, gnt, done, tx_start, tx_sel, tx_abort, arp_drop_cnt
   );

endinterface

// File: rtl/eth_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above i_ptr, wrapping to 0.
module rr_arbiter
   import eth_tx_arbiter_pkg::*;
#(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = idx_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      for (int unsigned j = 0; j < N; j++) begin
         if (!o_valid && i_req[j] && (j >= 32'(i_ptr))) begin
            o_valid = 1'b1;
            o_idx   = IW'(j);
         end
      end
      for (int unsigned j = 0; j < N; j++) begin
         if (!o_valid && i_req[j]) begin
            o_valid = 1'b1;
            o_idx   = IW'(j);
         end
      end
      o_gnt = o_valid ? (N'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares the MAC TX frame engine: ARP replies get strict priority, other sources round-robin.
module eth_tx_arbiter
   import eth_tx_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter int unsigned IFG_CYC     = 12
) (
   input  logic              aclk,
   input  logic              aresetn,
   eth_tx_arbiter_if.master  bus
);

   localparam int unsigned    IW       = idx_w(NUM_REQ);
   localparam int unsigned    WW       = idx_w(TIMEOUT_CYC);
   localparam int unsigned    GW       = idx_w(IFG_CYC + 1);
   localparam logic [WW-1:0]  WD_LAST  = WW'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0]  GAP_LOAD = (IFG_CYC > 0) ? GW'(IFG_CYC - 1) : '0;

   tx_arb_state_t      r_state, w_nxt_state;
   logic [NUM_REQ-1:0] r_gnt, w_nxt_gnt, r_done, w_nxt_done;
   logic               r_arp_gnt, w_nxt_arp_gnt, r_arp_done, w_nxt_arp_done;
   logic               r_tx_start, w_nxt_tx_start, r_tx_abort, w_nxt_tx_abort;
   tx_src_t            r_tx_sel, w_nxt_tx_sel;
   logic [IW-1:0]      r_rr_ptr, w_nxt_rr_ptr, r_idx, w_nxt_idx;
   logic [WW-1:0]      r_wdog, w_nxt_wdog;
   logic [GW-1:0]      r_gap, w_nxt_gap;
   logic               r_arp_pend, w_arp_want, w_arp_clr;
   logic [7:0]         r_drop;
   logic [NUM_REQ-1:0] w_rr_gnt;
   logic [IW-1:0]      w_rr_idx;
   logic               w_rr_valid;

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
      .i_req   (bus.req),
      .i_ptr   (r_rr_ptr),
      .o_gnt   (w_rr_gnt),
      .o_idx   (w_rr_idx),
      .o_valid (w_rr_valid)
   );

   // Raw pulse also counts so an idle engine starts ARP one cycle after the request.
   assign w_arp_want = r_arp_pend | bus.arp_resp_req;

   always_comb begin
      w_nxt_state    = r_state;
      w_nxt_gnt      = r_gnt;
      w_nxt_arp_gnt  = r_arp_gnt;
      w_nxt_tx_sel   = r_tx_sel;
      w_nxt_idx      = r_idx;
      w_nxt_rr_ptr   = r_rr_ptr;
      w_nxt_wdog     = r_wdog;
      w_nxt_gap      = r_gap;
      w_nxt_tx_start = 1'b0;
      w_nxt_tx_abort = 1'b0;
      w_nxt_done     = '0;
      w_nxt_arp_done = 1'b0;
      w_arp_clr      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_arp_want) begin
               w_nxt_state    = START;
               w_nxt_tx_start = 1'b1;
               w_nxt_arp_gnt  = 1'b1;
               w_nxt_gnt      = '0;
               w_nxt_tx_sel   = SRC_ARP;
            end else if (w_rr_valid) begin
               w_nxt_state    = START;
               w_nxt_tx_start = 1'b1;
               w_nxt_gnt      = w_rr_gnt;
               w_nxt_idx      = w_rr_idx;
               w_nxt_tx_sel   = tx_src_t'(w_rr_idx) + 3'd1;
            end
         end
         START: begin
            w_nxt_state = WAIT_DONE;
            w_nxt_wdog  = '0;
         end
         WAIT_DONE: begin
            w_nxt_wdog = r_wdog + 1'b1;
            // tx_done on the watchdog's last cycle is a normal completion.
            if (bus.tx_done || (r_wdog == WD_LAST)) begin
               w_nxt_tx_abort = !bus.tx_done;
               w_nxt_gnt      = '0;
               w_nxt_arp_gnt  = 1'b0;
               w_nxt_gap      = GAP_LOAD;
               w_nxt_state    = (IFG_CYC == 0) ? IDLE : GAP;
               if (r_arp_gnt) begin
                  w_nxt_arp_done = 1'b1;
                  w_arp_clr      = 1'b1;
               end else begin
                  w_nxt_done   = r_gnt;
                  w_nxt_rr_ptr = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
               end
            end
         end
         GAP: begin
            if (r_gap == '0) w_nxt_state = IDLE;
            else             w_nxt_gap   = r_gap - 1'b1;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_arp_gnt  <= 1'b0;
         r_done     <= '0;
         r_arp_done <= 1'b0;
         r_tx_start <= 1'b0;
         r_tx_abort <= 1'b0;
         r_tx_sel   <= '0;
         r_idx      <= '0;
         r_rr_ptr   <= '0;
         r_wdog     <= '0;
         r_gap      <= '0;
         r_arp_pend <= 1'b0;
         r_drop     <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_gnt      <= w_nxt_gnt;
         r_arp_gnt  <= w_nxt_arp_gnt;
         r_done     <= w_nxt_done;
         r_arp_done <= w_nxt_arp_done;
         r_tx_start <= w_nxt_tx_start;
         r_tx_abort <= w_nxt_tx_abort;
         r_tx_sel   <= w_nxt_tx_sel;
         r_idx      <= w_nxt_idx;
         r_rr_ptr   <= w_nxt_rr_ptr;
         r_wdog     <= w_nxt_wdog;
         r_gap      <= w_nxt_gap;
         // A new request wins over the clear from a finishing ARP frame.
         r_arp_pend <= bus.arp_resp_req | (r_arp_pend & ~w_arp_clr);
         if (bus.arp_resp_req && r_arp_pend && !w_arp_clr && (r_drop != 8'hFF))
            r_drop <= r_drop + 8'd1;
      end
   end

   assign bus.gnt          = r_gnt;
   assign bus.arp_gnt      = r_arp_gnt;
   assign bus.done         = r_done;
   assign bus.arp_done     = r_arp_done;
   assign bus.tx_start     = r_tx_start;
   assign bus.tx_abort     = r_tx_abort;
   assign bus.tx_sel       = r_tx_sel;
   assign bus.arp_drop_cnt = r_drop;

endmodule
